// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared types for the resonator-network factorizer
package hdc_pkg;

   localparam int DEF_VECTOR_LEN   = 32;
   localparam int DEF_NUM_FEATURES = 3;

   typedef logic [DEF_VECTOR_LEN-1:0] vec_t;
   typedef vec_t [DEF_NUM_FEATURES-1:0] est_arr_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_DRIVE  = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/feature_unbind.sv
// rtl/feature_unbind.sv - per-feature XOR of every other feature's estimate
module feature_unbind
   import hdc_pkg::*;
#(
   parameter int VECTOR_LEN   = DEF_VECTOR_LEN,
   parameter int NUM_FEATURES = DEF_NUM_FEATURES
) (
   input  logic [NUM_FEATURES*VECTOR_LEN-1:0] i_est,
   output logic [NUM_FEATURES*VECTOR_LEN-1:0] o_o_hat
);

   always_comb begin
      o_o_hat = '0;
      for (int k = 0; k < NUM_FEATURES; k++) begin
         for (int j = 0; j < NUM_FEATURES; j++) begin
            if (j != k) begin
               o_o_hat[k*VECTOR_LEN +: VECTOR_LEN] =
                  o_o_hat[k*VECTOR_LEN +: VECTOR_LEN] ^ i_est[j*VECTOR_LEN +: VECTOR_LEN];
            end
         end
      end
   end

endmodule

// File: rtl/resonator_ctrl.sv
// rtl/resonator_ctrl.sv - iteration controller driving the factor_feature bank
module resonator_ctrl
   import hdc_pkg::*;
#(
   parameter int VECTOR_LEN   = 32,
   parameter int NUM_FEATURES = 3,
   parameter int MAX_ITER     = 64,
   parameter int ITER_W       = $clog2(MAX_ITER+1)
) (
   input  logic                               i_clk,
   input  logic                               i_rstn,
   input  logic                               i_start,
   input  logic                               i_abort,
   input  logic [VECTOR_LEN-1:0]              i_scene,
   input  logic [NUM_FEATURES*VECTOR_LEN-1:0] i_init_est,
   output logic [VECTOR_LEN-1:0]              o_s,
   output logic [NUM_FEATURES*VECTOR_LEN-1:0] o_o_hat,
   input  logic [NUM_FEATURES*VECTOR_LEN-1:0] i_x_hat,
   input  logic [NUM_FEATURES-1:0]            i_conv,
   output logic                               o_busy,
   output logic                               o_done,
   output logic                               o_converged,
   output logic                               o_timeout,
   output logic [ITER_W-1:0]                  o_iter_count,
   output logic [NUM_FEATURES*VECTOR_LEN-1:0] o_est
);

   localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

   ctrl_state_t       state;
   logic [ITER_W-1:0] next_count;

   assign next_count = o_iter_count + ITER_W'(1);

   // o_hat depends only on the estimate registers, so it is stable through DRIVE and SAMPLE
   feature_unbind #(
      .VECTOR_LEN   (VECTOR_LEN),
      .NUM_FEATURES (NUM_FEATURES)
   ) u_unbind (
      .i_est   (o_est),
      .o_o_hat (o_o_hat)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state        <= ST_IDLE;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_converged  <= 1'b0;
         o_timeout    <= 1'b0;
         o_iter_count <= '0;
         o_s          <= '0;
         o_est        <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  o_s          <= i_scene;
                  o_est        <= i_init_est;
                  o_iter_count <= '0;
                  o_converged  <= 1'b0;
                  o_timeout    <= 1'b0;
                  o_busy       <= 1'b1;
                  state        <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (i_abort) begin
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  state  <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (i_abort) begin
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  state  <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               // abort wins over the iteration decision and leaves estimates untouched
               if (i_abort) begin
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  o_est        <= i_x_hat;
                  o_iter_count <= next_count;
                  if (&i_conv) begin
                     o_converged <= 1'b1;
                     o_busy      <= 1'b0;
                     o_done      <= 1'b1;
                     state       <= ST_DONE;
                  end else if (next_count == ITER_LIMIT) begin
                     o_timeout <= 1'b1;
                     o_busy    <= 1'b0;
                     o_done    <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state <= ST_DRIVE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_resonator_ctrl.sv
// tb/tb_resonator_ctrl.sv - directed bench for resonator_ctrl with stubbed factor units
module tb_resonator_ctrl;

   localparam int VL  = 32;
   localparam int NF  = 3;
   localparam int MI  = 4;
   localparam int IW  = $clog2(MI+1);

   localparam logic [31:0] A = 32'hA5A5_0F0F;
   localparam logic [31:0] B = 32'h1234_5678;
   localparam logic [31:0] C = 32'hDEAD_BEEF;
   localparam logic [31:0] P = 32'h0F0F_F0F0;
   localparam logic [31:0] Q = 32'h3333_CCCC;
   localparam logic [31:0] R = 32'h5A5A_9696;
   localparam logic [31:0] S = 32'hCAFE_F00D;

   logic              i_clk = 1'b0;
   logic              i_rstn = 1'b0;
   logic              i_start = 1'b0;
   logic              i_abort = 1'b0;
   logic [VL-1:0]     i_scene = '0;
   logic [NF*VL-1:0]  i_init_est = '0;
   logic [VL-1:0]     o_s;
   logic [NF*VL-1:0]  o_o_hat;
   logic [NF*VL-1:0]  i_x_hat = '0;
   logic [NF-1:0]     i_conv = '0;
   logic              o_busy;
   logic              o_done;
   logic              o_converged;
   logic              o_timeout;
   logic [IW-1:0]     o_iter_count;
   logic [NF*VL-1:0]  o_est;

   int pass_cnt = 0;
   int total_cnt = 0;

   resonator_ctrl #(
      .VECTOR_LEN   (VL),
      .NUM_FEATURES (NF),
      .MAX_ITER     (MI),
      .ITER_W       (IW)
   ) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .i_scene      (i_scene),
      .i_init_est   (i_init_est),
      .o_s          (o_s),
      .o_o_hat      (o_o_hat),
      .i_x_hat      (i_x_hat),
      .i_conv       (i_conv),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_converged  (o_converged),
      .o_timeout    (o_timeout),
      .o_iter_count (o_iter_count),
      .o_est        (o_est)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      tick();
      tick();
      total_cnt++;
      if ({o_busy, o_done, o_converged, o_timeout} !== 4'b0000)
         $display("FAIL reset_flags got %b exp 0000", {o_busy, o_done, o_converged, o_timeout});
      else pass_cnt++;
      total_cnt++;
      if (o_iter_count !== '0 || o_s !== '0 || o_est !== '0 || o_o_hat !== '0)
         $display("FAIL reset_data got cnt=%0d s=%h est=%h ohat=%h exp all zero", o_iter_count, o_s, o_est, o_o_hat);
      else pass_cnt++;
      i_rstn = 1'b1;
      tick();
   endtask

   task automatic test_converge_first();
      int cyc;
      i_scene = S;
      i_init_est = {C, B, A};
      i_x_hat = {C, B, A};
      i_conv = 3'b111;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      cyc = 2;
      total_cnt++;
      if (o_o_hat[VL-1:0] !== (B ^ C) || o_o_hat[2*VL-1:VL] !== (A ^ C) || o_o_hat[3*VL-1:2*VL] !== (A ^ B))
         $display("FAIL conv_ohat got %h exp %h", o_o_hat, {A ^ B, A ^ C, B ^ C});
      else pass_cnt++;
      total_cnt++;
      if (o_busy !== 1'b1 || o_s !== S)
         $display("FAIL conv_busy_s got busy=%b s=%h exp busy=1 s=%h", o_busy, o_s, S);
      else pass_cnt++;
      while (!o_done && cyc < 30) begin
         tick();
         cyc++;
      end
      total_cnt++;
      if (cyc !== 4) $display("FAIL conv_latency got %0d exp 4", cyc);
      else pass_cnt++;
      total_cnt++;
      if (o_converged !== 1'b1 || o_timeout !== 1'b0 || o_busy !== 1'b0 || o_iter_count !== IW'(1))
         $display("FAIL conv_result got conv=%b to=%b busy=%b cnt=%0d exp 1 0 0 1", o_converged, o_timeout, o_busy, o_iter_count);
      else pass_cnt++;
      total_cnt++;
      if (o_est !== {C, B, A}) $display("FAIL conv_est got %h exp %h", o_est, {C, B, A});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (o_done !== 1'b0 || o_converged !== 1'b1 || o_iter_count !== IW'(1))
         $display("FAIL conv_hold got done=%b conv=%b cnt=%0d exp 0 1 1", o_done, o_converged, o_iter_count);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int cyc;
      i_init_est = {R, Q, P};
      i_x_hat = {C, B, A};
      i_conv = 3'b011;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      total_cnt++;
      if (o_o_hat[VL-1:0] !== (Q ^ R)) $display("FAIL to_ohat_it1 got %h exp %h", o_o_hat[VL-1:0], Q ^ R);
      else pass_cnt++;
      tick();
      tick();
      cyc = 4;
      total_cnt++;
      if (o_o_hat[VL-1:0] !== (B ^ C) || o_o_hat[3*VL-1:2*VL] !== (A ^ B) || o_iter_count !== IW'(1))
         $display("FAIL to_ohat_it2 got %h cnt=%0d exp %h %h cnt=1", o_o_hat, o_iter_count, A ^ B, B ^ C);
      else pass_cnt++;
      while (!o_done && cyc < 30) begin
         tick();
         cyc++;
      end
      total_cnt++;
      if (cyc !== 10) $display("FAIL to_latency got %0d exp 10", cyc);
      else pass_cnt++;
      total_cnt++;
      if (o_timeout !== 1'b1 || o_converged !== 1'b0 || o_iter_count !== IW'(4))
         $display("FAIL to_result got to=%b conv=%b cnt=%0d exp 1 0 4", o_timeout, o_converged, o_iter_count);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_conv_on_last();
      int cyc;
      i_init_est = {R, Q, P};
      i_x_hat = {C, B, A};
      i_conv = 3'b011;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      cyc = 1;
      while (!o_done && cyc < 30) begin
         if (cyc == 8) i_conv = 3'b111;
         tick();
         cyc++;
      end
      total_cnt++;
      if (cyc !== 10) $display("FAIL last_latency got %0d exp 10", cyc);
      else pass_cnt++;
      total_cnt++;
      if (o_converged !== 1'b1 || o_timeout !== 1'b0 || o_iter_count !== IW'(4))
         $display("FAIL last_priority got conv=%b to=%b cnt=%0d exp 1 0 4", o_converged, o_timeout, o_iter_count);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_abort();
      int done_seen;
      done_seen = 0;
      i_init_est = {R, Q, P};
      i_x_hat = {C, B, A};
      i_conv = 3'b000;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      total_cnt++;
      if (o_iter_count !== IW'(1) || o_busy !== 1'b1)
         $display("FAIL abort_pre got cnt=%0d busy=%b exp 1 1", o_iter_count, o_busy);
      else pass_cnt++;
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      if (o_done) done_seen++;
      total_cnt++;
      if (o_busy !== 1'b0 || o_converged !== 1'b0 || o_timeout !== 1'b0 || o_iter_count !== IW'(1))
         $display("FAIL abort_state got busy=%b conv=%b to=%b cnt=%0d exp 0 0 0 1", o_busy, o_converged, o_timeout, o_iter_count);
      else pass_cnt++;
      total_cnt++;
      if (o_est !== {C, B, A}) $display("FAIL abort_est got %h exp %h", o_est, {C, B, A});
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_done) done_seen++;
      end
      total_cnt++;
      if (done_seen !== 0 || o_iter_count !== IW'(1))
         $display("FAIL abort_no_done got done_pulses=%0d cnt=%0d exp 0 1", done_seen, o_iter_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_sample();
      i_init_est = {C, B, A};
      i_x_hat = {R, Q, P};
      i_conv = 3'b000;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      tick();
      i_rstn = 1'b0;
      #1;
      total_cnt++;
      if ({o_busy, o_done, o_converged, o_timeout} !== 4'b0000 || o_iter_count !== '0)
         $display("FAIL midrst_flags got %b cnt=%0d exp 0000 0", {o_busy, o_done, o_converged, o_timeout}, o_iter_count);
      else pass_cnt++;
      total_cnt++;
      if (o_s !== '0 || o_est !== '0 || o_o_hat !== '0)
         $display("FAIL midrst_data got s=%h est=%h ohat=%h exp zero", o_s, o_est, o_o_hat);
      else pass_cnt++;
      tick();
      i_rstn = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_converge_first();
      test_timeout();
      test_conv_on_last();
      test_abort();
      test_reset_mid_sample();
      test_converge_first();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
